// File: rtl/fast_field_assembler_if.sv
// rtl/fast_field_assembler_if.sv - byte-lane input stream and assembled-field output stream bundle
//
// Purpose: carries the stop-bit-delimited FAST byte stream into the assembler
// and the decoded field words out of it.
// Signals:
//   s_axis_tdata/tkeep/tvalid/tlast -> assembler, s_axis_tready <- assembler
//   m_field_tdata/len/overflow/trunc/tlast/tvalid <- assembler, m_field_tready -> assembler
// Modports: master = stream source and field sink, slave = the assembler.
interface fast_field_assembler_if #(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_M_FIELD_WIDTH     = 64
);
  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep;
  logic                             s_axis_tvalid;
  logic                             s_axis_tready;
  logic                             s_axis_tlast;
  logic [C_M_FIELD_WIDTH-1:0]       m_field_tdata;
  logic [3:0]                       m_field_len;
  logic                             m_field_overflow;
  logic                             m_field_trunc;
  logic                             m_field_tlast;
  logic                             m_field_tvalid;
  logic                             m_field_tready;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_field_tdata, m_field_len, m_field_overflow, m_field_trunc,
           m_field_tlast, m_field_tvalid,
    output m_field_tready
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_field_tdata, m_field_len, m_field_overflow, m_field_trunc,
           m_field_tlast, m_field_tvalid,
    input  m_field_tready
  );
endinterface

// File: rtl/fast_field_assembler.sv
// rtl/fast_field_assembler.sv - FAST stop-bit field assembler (7-bit groups -> field words)
//
// Purpose: walks the kept byte lanes of each accepted beat one per cycle,
// concatenates the 7-bit payload groups MSB-first and emits one field word
// per stop byte, flagging oversize and packet-truncated fields.
// Ports:
//   axis_aclk        clock
//   axis_resetn      asynchronous active-low reset
//   bus              fast_field_assembler_if.slave (s_axis_* in, m_field_* out)
//   stat_field_count number of fields handed off downstream (wraps)
module fast_field_assembler #(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int MAX_FIELD_BYTES     = 9,
  parameter int C_M_FIELD_WIDTH     = 64
) (
  input  logic                  axis_aclk,
  input  logic                  axis_resetn,
  fast_field_assembler_if.slave bus,
  output logic [31:0]           stat_field_count
);
  localparam int         ACC_W   = 7 * MAX_FIELD_BYTES;
  localparam logic [3:0] MAX_CNT = 4'(MAX_FIELD_BYTES);

  // TRUNC is the extra cycle used to flush a partial field at packet end.
  typedef enum logic [1:0] {IDLE, SCAN, DISCARD, TRUNC} state_t;

  state_t                         state;
  logic [C_S_AXIS_DATA_WIDTH-1:0] beat_data;
  logic [7:0]                     beat_keep;
  logic                           beat_last;
  logic [2:0]                     idx;
  logic [ACC_W-1:0]               acc;
  logic [3:0]                     cnt;
  // Overflow discard still open when a beat ran out without tlast.
  logic                           drop_pending;

  logic                       o_valid, o_ovf, o_trunc, o_last;
  logic [C_M_FIELD_WIDTH-1:0] o_data;
  logic [3:0]                 o_len;
  logic [31:0]                field_count;

  logic [7:0]       avail, rest;
  logic [2:0]       cur_lane;
  logic [7:0]       cur_byte;
  logic             more, stall, is_stop, is_ovf;
  logic [ACC_W-1:0] acc_next;
  logic [3:0]       cnt_next;

  function automatic logic [C_M_FIELD_WIDTH-1:0] zext(input logic [ACC_W-1:0] v);
    logic [C_M_FIELD_WIDTH-1:0] r;
    r = '0;
    r[ACC_W-1:0] = v;
    return r;
  endfunction

  // Lowest kept lane at or above idx; unkept lanes cost no cycles.
  // 'more' tells whether a kept lane remains after the current one, so the
  // beat is known to be exhausted on the same cycle its last byte is used.
  always_comb begin
    avail    = beat_keep & (8'hff << idx);
    cur_lane = '0;
    for (int i = 7; i >= 0; i--) begin
      if (avail[i]) cur_lane = 3'(i);
    end
    rest     = avail & (8'hfe << cur_lane);
    more     = |rest;
    cur_byte = beat_data[{cur_lane, 3'b000} +: 8];
    acc_next = (acc << 7) | ACC_W'(cur_byte[6:0]);
    cnt_next = cnt + 4'd1;
    is_stop  = cur_byte[7];
    is_ovf   = !cur_byte[7] && (cnt_next == MAX_CNT);
  end

  assign stall = o_valid && !bus.m_field_tready;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state        <= IDLE;
      beat_data    <= '0;
      beat_keep    <= '0;
      beat_last    <= 1'b0;
      idx          <= '0;
      acc          <= '0;
      cnt          <= '0;
      drop_pending <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_len        <= '0;
      o_ovf        <= 1'b0;
      o_trunc      <= 1'b0;
      o_last       <= 1'b0;
      field_count  <= '0;
    end else begin
      // Drain first; a load below on the same edge takes precedence.
      if (o_valid && bus.m_field_tready) begin
        o_valid     <= 1'b0;
        field_count <= field_count + 32'd1;
      end
      case (state)
        IDLE: begin
          if (bus.s_axis_tvalid) begin
            beat_data <= bus.s_axis_tdata;
            beat_keep <= bus.s_axis_tkeep;
            beat_last <= bus.s_axis_tlast;
            idx       <= '0;
            if (bus.s_axis_tkeep == 8'h00) begin
              // Empty beat: only its tlast matters. cnt is always 0 while
              // a discard is pending, so no separate check is needed.
              if (bus.s_axis_tlast) begin
                drop_pending <= 1'b0;
                if (cnt != 4'd0) state <= TRUNC;
              end
            end else begin
              state <= drop_pending ? DISCARD : SCAN;
            end
          end
        end
        SCAN: begin
          if (!stall) begin
            if (is_stop || is_ovf) begin
              o_valid <= 1'b1;
              o_data  <= zext(acc_next);
              o_len   <= cnt_next;
              o_ovf   <= is_ovf;
              o_trunc <= 1'b0;
              o_last  <= beat_last && !more;
              acc     <= '0;
              cnt     <= '0;
            end else begin
              acc <= acc_next;
              cnt <= cnt_next;
            end
            if (more) begin
              idx   <= cur_lane + 3'd1;
              state <= is_ovf ? DISCARD : SCAN;
            end else if (is_ovf) begin
              drop_pending <= !beat_last;
              state        <= IDLE;
            end else if (beat_last && !is_stop) begin
              state <= TRUNC;
            end else begin
              state <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (!stall) begin
            if (more) idx <= cur_lane + 3'd1;
            if (is_stop) begin
              drop_pending <= 1'b0;
              state        <= more ? SCAN : IDLE;
            end else if (!more) begin
              drop_pending <= !beat_last;
              state        <= IDLE;
            end
          end
        end
        TRUNC: begin
          if (!stall) begin
            o_valid <= 1'b1;
            o_data  <= zext(acc);
            o_len   <= cnt;
            o_ovf   <= 1'b0;
            o_trunc <= 1'b1;
            o_last  <= 1'b1;
            acc     <= '0;
            cnt     <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_axis_tready    = (state == IDLE) && axis_resetn;
  assign bus.m_field_tvalid   = o_valid;
  assign bus.m_field_tdata    = o_data;
  assign bus.m_field_len      = o_len;
  assign bus.m_field_overflow = o_ovf;
  assign bus.m_field_trunc    = o_trunc;
  assign bus.m_field_tlast    = o_last;
  assign stat_field_count     = field_count;
endmodule

// File: tb/tb_fast_field_assembler.sv
// tb/tb_fast_field_assembler.sv - self-checking bench for fast_field_assembler
module tb_fast_field_assembler;
  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] stat_cnt;

  always #5 clk = ~clk;

  fast_field_assembler_if bus ();

  fast_field_assembler dut (
    .axis_aclk       (clk),
    .axis_resetn     (rstn),
    .bus             (bus),
    .stat_field_count(stat_cnt)
  );

  typedef struct packed {
    logic [63:0] v;
    logic [3:0]  len;
    logic        ovf;
    logic        trn;
    logic        lst;
  } fld_t;

  fld_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          hs_count = 0;
  bit          model_on = 1'b0;
  bit          rnd_ready = 1'b0;
  bit          mon_held = 1'b0;
  fld_t        mon_prev;
  logic [63:0] m_val = '0;
  int          m_len = 0;
  bit          m_disc = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] v, input int len, input bit ovf, input bit trn, input bit lst);
    fld_t f;
    f.v = v; f.len = 4'(len); f.ovf = ovf; f.trn = trn; f.lst = lst;
    exp_q.push_back(f);
  endtask

  // Reference: walk the kept bytes in stream order with plain arithmetic.
  task automatic model_beat(input logic [63:0] d, input logic [7:0] k, input bit last);
    int          lastk;
    logic [7:0]  b;
    lastk = -1;
    for (int i = 0; i < 8; i++) if (k[i]) lastk = i;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) begin
        b = d[8*i +: 8];
        if (m_disc) begin
          if (b[7]) m_disc = 1'b0;
        end else begin
          m_val = m_val * 128 + 64'(b[6:0]);
          m_len++;
          if (b[7] || m_len == 9) begin
            push_exp(m_val, m_len, !b[7], 1'b0, last && (i == lastk));
            m_disc = !b[7];
            m_val  = '0;
            m_len  = 0;
          end
        end
      end
    end
    if (last) begin
      if (m_len > 0) push_exp(m_val, m_len, 1'b0, 1'b1, 1'b1);
      m_val = '0; m_len = 0; m_disc = 1'b0;
    end
  endtask

  function automatic fld_t cur_out();
    fld_t f;
    f.v = bus.m_field_tdata; f.len = bus.m_field_len; f.ovf = bus.m_field_overflow;
    f.trn = bus.m_field_trunc; f.lst = bus.m_field_tlast;
    return f;
  endfunction

  // Output monitor: scoreboard on every handshake, stability while stalled.
  always @(negedge clk) begin
    fld_t cur, e;
    if (!rstn) begin
      mon_held = 1'b0;
    end else begin
      cur = cur_out();
      if (mon_held) begin
        check("hold_valid", bus.m_field_tvalid, 1'b1);
        check("hold_value", cur.v, mon_prev.v);
        check("hold_meta", {cur.len, cur.ovf, cur.trn, cur.lst}, {mon_prev.len, mon_prev.ovf, mon_prev.trn, mon_prev.lst});
      end
      if (bus.m_field_tvalid && bus.m_field_tready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check("extra_field_valid", bus.m_field_tvalid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("field_value", cur.v, e.v);
          check("field_len_ovf_trunc_last", {cur.len, cur.ovf, cur.trn, cur.lst}, {e.len, e.ovf, e.trn, e.lst});
        end
      end
      mon_held = bus.m_field_tvalid && !bus.m_field_tready;
      mon_prev = cur;
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #2;
      bus.m_field_tready = ($urandom_range(0, 9) < 7);
    end
  end

  task automatic set_ready(input bit v);
    @(posedge clk);
    #3;
    bus.m_field_tready = v;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    bus.s_axis_tlast  = last;
    bus.s_axis_tvalid = 1'b1;
    while (!bus.s_axis_tready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("s_axis_tready_timeout", n, 0);
    if (model_on) model_beat(d, k, last);
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic watch_valid(input int n, output logic [7:0] pat);
    pat = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pat = {pat[6:0], bus.m_field_tvalid};
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_s_axis_tready", bus.s_axis_tready, 1'b0);
    check("rst_m_field_tvalid", bus.m_field_tvalid, 1'b0);
    check("rst_m_field_tdata", bus.m_field_tdata, 64'h0);
    check("rst_m_field_meta", {bus.m_field_len, bus.m_field_overflow, bus.m_field_trunc, bus.m_field_tlast}, 7'h0);
    check("rst_stat_field_count", stat_cnt, 32'h0);
    exp_q.delete();
    m_val = '0; m_len = 0; m_disc = 1'b0; hs_count = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.s_axis_tready, 1'b1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pat;
    logic [63:0] d;
    logic [7:0]  k;
    int          nb, stop_pct;
    bus.s_axis_tdata   = '0;
    bus.s_axis_tkeep   = '0;
    bus.s_axis_tlast   = 1'b0;
    bus.s_axis_tvalid  = 1'b0;
    bus.m_field_tready = 1'b1;
    do_reset();

    // Single byte, one-cycle latency.
    push_exp(64'h1, 1, 0, 0, 1);
    send_beat(64'h81, 8'h01, 1'b1);
    watch_valid(3, pat);
    check("single_latency_pattern", pat, 8'b010);
    check("single_count", stat_cnt, 32'd1);

    // Two fields in one beat, back to back.
    push_exp(64'h82, 2, 0, 0, 0);
    push_exp(64'h5, 1, 0, 0, 1);
    send_beat(64'h85_8201, 8'h07, 1'b1);
    watch_valid(5, pat);
    check("two_field_pattern", pat, 8'b00110);

    // Field spanning two beats, nine bytes.
    push_exp(64'h7FFF_FFFF_FFFF_FF80, 9, 0, 0, 1);
    send_beat(64'h7F7F_7F7F_7F7F_7F7F, 8'hFF, 1'b0);
    send_beat(64'h80, 8'h01, 1'b1);

    // Overflow, then the next field decodes normally.
    push_exp(64'h0102_0408_1020_4081, 9, 1, 0, 0);
    push_exp(64'h4, 1, 0, 0, 1);
    send_beat(64'h0101_0101_0101_0101, 8'hFF, 1'b0);
    send_beat(64'h8483_0101, 8'h0F, 1'b1);
    drain();
    check("directed_count", stat_cnt, 32'd6);

    // Backpressure.
    do_reset();
    set_ready(1'b0);
    push_exp(64'h1, 1, 0, 0, 0);
    push_exp(64'h2, 1, 0, 0, 0);
    push_exp(64'h3, 1, 0, 0, 1);
    send_beat(64'h83_8281, 8'h07, 1'b1);
    repeat (5) @(negedge clk);
    check("stall_s_axis_tready", bus.s_axis_tready, 1'b0);
    check("stall_tvalid", bus.m_field_tvalid, 1'b1);
    check("stall_first_value", bus.m_field_tdata, 64'h1);
    check("stall_count", stat_cnt, 32'd0);
    set_ready(1'b1);
    drain();
    check("stall_drain_count", stat_cnt, 32'd3);

    // Truncated field at packet end.
    push_exp(64'h5, 1, 0, 1, 1);
    send_beat(64'h05, 8'h01, 1'b1);
    drain();

    // Reset in the middle of a field; nothing may leak into the next packet.
    send_beat(64'h0102_0304_0506_0708, 8'hFF, 1'b0);
    @(negedge clk);
    do_reset();
    push_exp(64'h5, 1, 0, 0, 1);
    send_beat(64'h85, 8'h01, 1'b1);
    drain();
    check("post_reset_count", stat_cnt, 32'd1);

    // Randomized packets against the reference model.
    model_on  = 1'b1;
    rnd_ready = 1'b1;
    for (int p = 0; p < 80; p++) begin
      nb       = $urandom_range(1, 4);
      stop_pct = ($urandom_range(0, 3) == 0) ? 3 : 35;
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 8; i++) begin
          d[8*i +: 8] = 8'($urandom_range(0, 255));
          d[8*i + 7]  = ($urandom_range(0, 99) < stop_pct);
        end
        case ($urandom_range(0, 5))
          0:       k = 8'hFF;
          1:       k = 8'h00;
          default: k = 8'($urandom_range(0, 255));
        endcase
        send_beat(d, k, b == nb - 1);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    rnd_ready = 1'b0;
    set_ready(1'b1);
    drain();
    check("random_queue_empty", exp_q.size(), 0);
    check("random_stat_count", stat_cnt, 32'(hs_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
